// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control path: opcodes, funct codes,
// ALU control codes, ALU-decoder selectors and multicycle state encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the controller's coarse ALU request plus the R-type
// funct field onto the 3-bit ALU operation code.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t      i_aluop,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct codes fall back to add rather than X
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath; memready
// stalls fetch, load and store until the memory completes the access.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memready,
  output logic        pcen,
  output logic        irwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        iord,
  output logic        memtoreg,
  output logic        regdst,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        halted,
  output logic [3:0]  state
);

  state_t r_state;
  state_t w_nextState;
  aluop_t w_aluop;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = S_FETCH;
    w_aluop     = ALUOP_ADD;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_regwrite  = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
        if (memready) w_nextState = S_DECODE;
        else          w_nextState = S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_RTYPE:     w_nextState = S_RTYPEEX;
          OP_BEQ:       w_nextState = S_BEQEX;
          OP_ADDI:      w_nextState = S_ADDIEX;
          OP_J:         w_nextState = S_JEX;
          default: begin
            if (HALT_ON_ILLEGAL) w_nextState = S_HALT;
            else                 w_nextState = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SW) w_nextState = S_MEMWR;
        else             w_nextState = S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) w_nextState = S_MEMWB;
        else          w_nextState = S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        // The write strobe stays up for the whole stall, not just the last cycle
        iord       = 1'b1;
        w_memwrite = 1'b1;
        if (memready) w_nextState = S_FETCH;
        else          w_nextState = S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca     = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_nextState = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        pcsrc    = 2'b01;
      end
      S_ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        w_nextState = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_HALT: begin
        halted      = 1'b1;
        w_nextState = S_HALT;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  mips_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

  // Write enables are also masked by reset so they drop without waiting for a clock
  assign pcen     = reset & (w_pcwrite | (w_branch & zero));
  assign irwrite  = reset & w_irwrite;
  assign memwrite = reset & w_memwrite;
  assign regwrite = reset & w_regwrite;
  assign state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and randomized instructions checked
// cycle by cycle against an instruction-level list of expected control words.
module tb_mips_multicycle_ctrl;

  typedef struct {
    logic [3:0] st;
    bit         stall;
    bit         gated;
    bit         pcen;
    bit         memwrite;
    bit         regwrite;
    bit         iord;
    bit         memtoreg;
    bit         regdst;
    bit         alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    bit         aluCare;
    logic [2:0] aluc;
  } step_t;

  logic       clk = 1'b0;
  logic       reset, resetH, zero, memready;
  logic [5:0] op, opH, funct;

  logic       sPcen, sIrwrite, sMemwrite, sRegwrite, sIord, sMemtoreg, sRegdst, sAlusrca, sHalted;
  logic [1:0] sAlusrcb, sPcsrc;
  logic [2:0] sAluc;
  logic [3:0] sState;
  logic       hPcen, hIrwrite, hMemwrite, hRegwrite, hIord, hMemtoreg, hRegdst, hAlusrca, hHalted;
  logic [1:0] hAlusrcb, hPcsrc;
  logic [2:0] hAluc;
  logic [3:0] hState;

  int    checkCount = 0;
  int    passCount  = 0;
  step_t plan[$];
  bit    readyQ[$];
  int    mwCycles;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dutSkip (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(sPcen), .irwrite(sIrwrite), .memwrite(sMemwrite), .regwrite(sRegwrite),
    .iord(sIord), .memtoreg(sMemtoreg), .regdst(sRegdst), .alusrca(sAlusrca),
    .alusrcb(sAlusrcb), .pcsrc(sPcsrc), .alucontrol(sAluc), .halted(sHalted), .state(sState)
  );

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dutHalt (
    .clk(clk), .reset(resetH), .op(opH), .funct(funct), .zero(zero), .memready(memready),
    .pcen(hPcen), .irwrite(hIrwrite), .memwrite(hMemwrite), .regwrite(hRegwrite),
    .iord(hIord), .memtoreg(hMemtoreg), .regdst(hRegdst), .alusrca(hAlusrca),
    .alusrcb(hAlusrcb), .pcsrc(hPcsrc), .alucontrol(hAluc), .halted(hHalted), .state(hState)
  );

  // Single point of comparison; every check in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
  endtask

  function automatic logic [2:0] aluFor(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int baseLatency(input logic [5:0] o);
    case (o)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:            return 3;
      default:                         return 2;
    endcase
  endfunction

  function automatic step_t blank(input logic [3:0] st);
    step_t s;
    s.st = st;       s.stall = 0;     s.gated = 0;    s.pcen = 0;
    s.memwrite = 0;  s.regwrite = 0;  s.iord = 0;     s.memtoreg = 0;
    s.regdst = 0;    s.alusrca = 0;   s.alusrcb = 2'b00;
    s.pcsrc = 2'b00; s.aluCare = 0;   s.aluc = 3'b010;
    return s;
  endfunction

  // Expected control words for one whole instruction, fetch through writeback
  task automatic buildPlan(input logic [5:0] iop, input logic [5:0] ifn, input logic iz);
    step_t s;
    plan.delete();
    s = blank(4'd0); s.stall = 1; s.gated = 1; s.alusrcb = 2'b01; s.aluCare = 1; plan.push_back(s);
    s = blank(4'd1); s.alusrcb = 2'b11; s.aluCare = 1; plan.push_back(s);
    case (iop)
      6'b100011, 6'b101011: begin
        s = blank(4'd2); s.alusrca = 1; s.alusrcb = 2'b10; s.aluCare = 1; plan.push_back(s);
        if (iop == 6'b100011) begin
          s = blank(4'd3); s.stall = 1; s.iord = 1; plan.push_back(s);
          s = blank(4'd4); s.regwrite = 1; s.memtoreg = 1; plan.push_back(s);
        end else begin
          s = blank(4'd5); s.stall = 1; s.iord = 1; s.memwrite = 1; plan.push_back(s);
        end
      end
      6'b000000: begin
        s = blank(4'd6); s.alusrca = 1; s.aluCare = 1; s.aluc = aluFor(ifn); plan.push_back(s);
        s = blank(4'd7); s.regwrite = 1; s.regdst = 1; plan.push_back(s);
      end
      6'b000100: begin
        s = blank(4'd8); s.alusrca = 1; s.aluCare = 1; s.aluc = 3'b110;
        s.pcen = iz; s.pcsrc = 2'b01; plan.push_back(s);
      end
      6'b001000: begin
        s = blank(4'd9); s.alusrca = 1; s.alusrcb = 2'b10; s.aluCare = 1; plan.push_back(s);
        s = blank(4'd10); s.regwrite = 1; plan.push_back(s);
      end
      6'b000010: begin
        s = blank(4'd11); s.pcsrc = 2'b10; s.pcen = 1; plan.push_back(s);
      end
      default: ;
    endcase
  endtask

  task automatic checkStep(input step_t e);
    checkOutput("state",    32'(sState),    32'(e.st));
    checkOutput("pcen",     32'(sPcen),     32'(e.gated ? memready : e.pcen));
    checkOutput("irwrite",  32'(sIrwrite),  32'(e.gated ? memready : 1'b0));
    checkOutput("memwrite", 32'(sMemwrite), 32'(e.memwrite));
    checkOutput("regwrite", 32'(sRegwrite), 32'(e.regwrite));
    checkOutput("iord",     32'(sIord),     32'(e.iord));
    checkOutput("memtoreg", 32'(sMemtoreg), 32'(e.memtoreg));
    checkOutput("regdst",   32'(sRegdst),   32'(e.regdst));
    checkOutput("alusrca",  32'(sAlusrca),  32'(e.alusrca));
    checkOutput("alusrcb",  32'(sAlusrcb),  32'(e.alusrcb));
    checkOutput("pcsrc",    32'(sPcsrc),    32'(e.pcsrc));
    checkOutput("halted",   32'(sHalted),   32'(0));
    if (e.aluCare) checkOutput("alucontrol", 32'(sAluc), 32'(e.aluc));
  endtask

  // Runs one instruction on dutSkip starting at a falling edge in FETCH
  task automatic applyStimulus(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                               input int readyPct, output int mwSeen);
    int idx = 0;
    int cycles = 0;
    int stalls = 0;
    int dutLat = -1;
    bit leftFetch = 0;
    buildPlan(iop, ifn, iz);
    op = iop; funct = ifn; zero = iz; mwSeen = 0;
    while (idx < plan.size() && cycles < 100) begin
      if (readyQ.size() > 0) memready = readyQ.pop_front();
      else memready = (int'($urandom_range(99)) < readyPct);
      #1;
      checkStep(plan[idx]);
      if (sMemwrite) mwSeen++;
      @(posedge clk);
      cycles++;
      if (plan[idx].stall && !memready) stalls++;
      else idx++;
      @(negedge clk);
      if (sState != 4'd0) leftFetch = 1;
      else if (leftFetch && dutLat < 0) dutLat = cycles;
    end
    checkOutput("planDone", 32'(idx), 32'(plan.size()));
    checkOutput("latency", 32'(dutLat), 32'(baseLatency(iop) + stalls));
  endtask

  initial begin
    reset = 0; resetH = 0; memready = 1; zero = 0;
    op = 6'b0; opH = 6'b0; funct = 6'b0;
    @(negedge clk); #1;
    checkOutput("rstState",    32'(sState),    32'(0));
    checkOutput("rstPcen",     32'(sPcen),     32'(0));
    checkOutput("rstIrwrite",  32'(sIrwrite),  32'(0));
    checkOutput("rstMemwrite", 32'(sMemwrite), 32'(0));
    checkOutput("rstRegwrite", 32'(sRegwrite), 32'(0));
    checkOutput("rstIord",     32'(sIord),     32'(0));
    checkOutput("rstAlusrca",  32'(sAlusrca),  32'(0));
    checkOutput("rstAlusrcb",  32'(sAlusrcb),  32'(1));
    checkOutput("rstPcsrc",    32'(sPcsrc),    32'(0));
    checkOutput("rstAluc",     32'(sAluc),     32'(3'b010));
    checkOutput("rstHalted",   32'(sHalted),   32'(0));
    checkOutput("rstHPcen",    32'(hPcen),     32'(0));
    checkOutput("rstHIrwrite", 32'(hIrwrite),  32'(0));
    checkOutput("rstHAluc",    32'(hAluc),     32'(3'b010));
    checkOutput("rstHAlusrcb", 32'(hAlusrcb),  32'(1));
    @(negedge clk);
    reset = 1;

    $display("[TB] directed instructions");
    applyStimulus(6'b100011, 6'b000000, 1'b0, 100, mwCycles);
    applyStimulus(6'b000000, 6'b100101, 1'b0, 100, mwCycles);
    applyStimulus(6'b000100, 6'b000000, 1'b1, 100, mwCycles);
    applyStimulus(6'b000100, 6'b000000, 1'b0, 100, mwCycles);
    applyStimulus(6'b001000, 6'b000000, 1'b0, 100, mwCycles);
    applyStimulus(6'b000010, 6'b000000, 1'b0, 100, mwCycles);
    readyQ = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    applyStimulus(6'b101011, 6'b000000, 1'b0, 100, mwCycles);
    checkOutput("swMemwriteCycles", 32'(mwCycles), 32'(4));
    applyStimulus(6'b111111, 6'b000000, 1'b0, 100, mwCycles);

    $display("[TB] reset during MEMWR");
    op = 6'b101011; memready = 1;
    repeat (3) @(negedge clk);
    memready = 0; #1;
    checkOutput("midState",    32'(sState),    32'(5));
    checkOutput("midMemwrite", 32'(sMemwrite), 32'(1));
    #2;
    memready = 1; reset = 0; #1;
    checkOutput("asyncMemwrite", 32'(sMemwrite), 32'(0));
    checkOutput("asyncState",    32'(sState),    32'(0));
    checkOutput("asyncPcen",     32'(sPcen),     32'(0));
    checkOutput("asyncIrwrite",  32'(sIrwrite),  32'(0));
    @(negedge clk);
    reset = 1;
    applyStimulus(6'b001000, 6'b000000, 1'b0, 100, mwCycles);

    $display("[TB] halt on illegal opcode");
    reset = 0; opH = 6'b111111; memready = 1;
    @(negedge clk);
    resetH = 1;
    for (int c = 0; c < 24; c++) begin
      #1;
      checkOutput("haltState", 32'(hState), 32'((c == 0) ? 0 : (c == 1) ? 1 : 12));
      checkOutput("haltFlag",  32'(hHalted), 32'(c >= 2));
      if (c >= 2) begin
        checkOutput("haltPcen",     32'(hPcen),      32'(0));
        checkOutput("haltIrwrite",  32'(hIrwrite),   32'(0));
        checkOutput("haltMemwrite", 32'(hMemwrite),  32'(0));
        checkOutput("haltRegwrite", 32'(hRegwrite),  32'(0));
        checkOutput("haltSelects",
                    32'({hIord, hMemtoreg, hRegdst, hAlusrca, hAlusrcb, hPcsrc}), 32'(0));
      end
      @(negedge clk);
    end
    resetH = 0; #1;
    checkOutput("haltResetState", 32'(hState),  32'(0));
    checkOutput("haltResetFlag",  32'(hHalted), 32'(0));
    @(negedge clk);
    reset = 1;

    $display("[TB] randomized instruction stream");
    for (int n = 0; n < 250; n++) begin
      logic [5:0] rop, rfn;
      case ($urandom_range(6))
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        5: rop = 6'b000010;
        default: rop = 6'($urandom);
      endcase
      case ($urandom_range(5))
        0: rfn = 6'b100000;
        1: rfn = 6'b100010;
        2: rfn = 6'b100100;
        3: rfn = 6'b100101;
        4: rfn = 6'b101010;
        default: rfn = 6'($urandom);
      endcase
      applyStimulus(rop, rfn, 1'($urandom), int'($urandom_range(100, 60)), mwCycles);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
